// File: rtl/z380_wait_sched_pkg.sv
// Shared z380 platform definitions for the wait-state scheduler slice.
package z380_wait_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } wait_sched_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_W = 10;

  // Width of an index into n requesters, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z380_wait_sched_if.sv
// Requester and waitgen handshake bundle for z380_wait_sched.
interface z380_wait_sched_if #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned INDEX_W = 3
);
  logic [NREQ-1:0]         rq_valid;
  logic [NREQ*INDEX_W-1:0] rq_profile;
  logic [NREQ-1:0]         rq_lock;
  logic [NREQ-1:0]         rq_ready;
  logic [NREQ-1:0]         rq_done;
  logic [NREQ-1:0]         rq_err;
  logic                    wg_req_valid;
  logic [INDEX_W-1:0]      wg_req_profile;
  logic                    wg_req_ready;
  logic                    wg_wait_done;

  modport slave (
    input  rq_valid, rq_profile, rq_lock, wg_req_ready, wg_wait_done,
    output rq_ready, rq_done, rq_err, wg_req_valid, wg_req_profile
  );

  modport master (
    output rq_valid, rq_profile, rq_lock, wg_req_ready, wg_wait_done,
    input  rq_ready, rq_done, rq_err, wg_req_valid, wg_req_profile
  );
endinterface

// File: rtl/z380_rr_arb.sv
// Round-robin arbiter with a lock override that pins the grant to one index.
module z380_rr_arb
  import z380_wait_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             lock_en_i,
  input  logic [IDX_W-1:0] lock_idx_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    if (lock_en_i) begin
      // Locked: only the holder may win; everyone else waits.
      if (req_i[lock_idx_i]) begin
        gnt_o[lock_idx_i] = 1'b1;
        gnt_idx_o         = lock_idx_i;
        gnt_valid_o       = 1'b1;
      end
    end else begin
      for (int unsigned off = 1; off <= NREQ; off++) begin
        cand = IDX_W'((32'(ptr_i) + off) % NREQ);
        if (!gnt_valid_o && req_i[cand]) begin
          gnt_o[cand] = 1'b1;
          gnt_idx_o   = cand;
          gnt_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/z380_wait_sched.sv
// Schedules requesters one at a time onto the shared Z380 wait-state generator.
module z380_wait_sched
  import z380_wait_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned INDEX_W   = 3,
  parameter int unsigned TIMEOUT_W = DEFAULT_TIMEOUT_W,
  localparam int unsigned OW       = idx_w(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  z380_wait_sched_if.slave    bus,
  output logic                busy,
  output logic [OW-1:0]       owner
);

  wait_sched_state_t state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [INDEX_W-1:0]   prof_q, prof_d, prof_sel;
  logic [NREQ-1:0]      done_q, done_d;
  logic [NREQ-1:0]      err_q, err_d;
  logic [NREQ-1:0]      rdy_c;
  logic                 wgv_c;

  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   gnt_idx;
  logic            gnt_valid;

  z380_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (OW)
  ) u_arb (
    .req_i       (bus.rq_valid),
    .ptr_i       (ptr_q),
    .lock_en_i   (lock_q),
    .lock_idx_i  (owner_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    prof_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) prof_sel = bus.rq_profile[i*INDEX_W +: INDEX_W];
    end
  end

  assign wdog_inc = wdog_q + TIMEOUT_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    wdog_d  = wdog_q;
    prof_d  = prof_q;
    done_d  = '0;
    err_d   = '0;
    rdy_c   = '0;
    wgv_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lock_q && !bus.rq_lock[owner_q]) lock_d = 1'b0;
        if (gnt_valid) begin
          rdy_c   = gnt;
          owner_d = gnt_idx;
          ptr_d   = gnt_idx;
          prof_d  = prof_sel;
          state_d = ST_ISSUE;
        end
      end
      // A done arriving alongside the accept belongs to an earlier cycle and is dropped.
      ST_ISSUE: begin
        wgv_c = 1'b1;
        if (bus.wg_req_ready) begin
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.wg_wait_done) begin
          done_d[owner_q] = 1'b1;
          lock_d          = bus.rq_lock[owner_q];
          state_d         = ST_IDLE;
        end else if (wdog_inc == '1) begin
          err_d[owner_q] = 1'b1;
          lock_d         = 1'b0;
          wdog_d         = '0;
          state_d        = ST_IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= OW'(NREQ - 1);
      lock_q  <= 1'b0;
      wdog_q  <= '0;
      prof_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      wdog_q  <= wdog_d;
      prof_q  <= prof_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // rq_ready is combinational from rq_valid, so hold it low while reset is asserted.
  assign bus.rq_ready       = rdy_c & {NREQ{rst_n}};
  assign bus.rq_done        = done_q;
  assign bus.rq_err         = err_q;
  assign bus.wg_req_valid   = wgv_c;
  assign bus.wg_req_profile = prof_q;
  assign busy               = (state_q != ST_IDLE);
  assign owner              = owner_q;

endmodule

// File: tb/tb_z380_wait_sched.sv
// Directed bench for z380_wait_sched with a small waitgen model and grant/done monitor.
module tb_z380_wait_sched;
  localparam int unsigned NREQ = 4, INDEX_W = 3, TIMEOUT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] owner;
  logic       mute, inject;

  z380_wait_sched_if #(.NREQ(NREQ), .INDEX_W(INDEX_W)) bus ();

  z380_wait_sched #(
    .NREQ      (NREQ),
    .INDEX_W   (INDEX_W),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  // Waitgen model: accepts when idle, signals done after 'profile' extra cycles.
  logic       gen_busy;
  logic [2:0] gen_cnt;
  assign bus.wg_req_ready = !gen_busy;
  assign bus.wg_wait_done = (gen_busy && gen_cnt == 3'd0 && !mute) || inject;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_busy <= 1'b0;
      gen_cnt  <= 3'd0;
    end else if (!gen_busy) begin
      if (bus.wg_req_valid) begin
        gen_busy <= 1'b1;
        gen_cnt  <= bus.wg_req_profile;
      end
    end else if (gen_cnt == 3'd0) begin
      if (!mute) gen_busy <= 1'b0;
    end else begin
      gen_cnt <= gen_cnt - 3'd1;
    end
  end

  // Monitor: grant order, completion log and protocol violation counters.
  int  grant_q[$];
  int  done_idx_q[$];
  int  done_cyc_q[$];
  int  multihot = 0, overlap = 0, dup = 0, cyc = 0;
  bit  inflight = 1'b0;

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < int'(NREQ); i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] comp;
    cyc++;
    if (!rst_n) begin
      inflight = 1'b0;
    end else begin
      comp = bus.rq_done | bus.rq_err;
      if (comp != '0) begin
        if (!$onehot(comp) || (bus.rq_done & bus.rq_err) != '0) multihot++;
        if (!inflight) dup++;
        inflight = 1'b0;
        if (bus.rq_done != '0) begin
          done_idx_q.push_back(oh2idx(bus.rq_done));
          done_cyc_q.push_back(cyc);
        end
      end
      if (bus.rq_ready != '0) begin
        if (!$onehot(bus.rq_ready) || (bus.rq_ready & ~bus.rq_valid) != '0) multihot++;
        if (inflight) overlap++;
        inflight = 1'b1;
        grant_q.push_back(oh2idx(bus.rq_ready));
      end
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_prof(input int i, input logic [INDEX_W-1:0] p);
    bus.rq_profile[i*INDEX_W +: INDEX_W] = p;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    check(tag, busy, 0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.rq_valid = '0;
    bus.rq_lock  = '0;
    mute         = 1'b0;
    inject       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int exp2[6];
    int exp3[4];
    int waits;
    int got;

    rst_n          = 1'b0;
    bus.rq_valid   = '0;
    bus.rq_lock    = '0;
    bus.rq_profile = '0;
    mute           = 1'b0;
    inject         = 1'b0;
    bus.rq_valid   = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.rq_ready, 0);
    check("rst_done", bus.rq_done, 0);
    check("rst_err", bus.rq_err, 0);
    check("rst_wgv", bus.wg_req_valid, 0);
    check("rst_wgprof", bus.wg_req_profile, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    bus.rq_valid = '0;
    rst_n        = 1'b1;

    // Single requester 0, profile 3
    set_prof(0, 3'd3);
    bus.rq_valid = 4'b0001;
    tick();
    check("t1_ready", bus.rq_ready, 4'b0001);
    @(posedge clk); #1 bus.rq_valid = '0;
    tick();
    check("t1_wgv", bus.wg_req_valid, 1);
    check("t1_wgprof", bus.wg_req_profile, 3);
    check("t1_ready_off", bus.rq_ready, 0);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 20 && !bus.wg_wait_done; i++) tick();
    check("t1_wgdone_seen", bus.wg_wait_done, 1);
    check("t1_no_early_done", bus.rq_done, 0);
    tick();
    check("t1_done", bus.rq_done, 4'b0001);
    check("t1_idle", busy, 0);
    tick();
    check("t1_done_pulse", bus.rq_done, 0);

    // All four valid, no lock: plain round robin from pointer NREQ-1
    do_reset();
    grant_q.delete();
    done_idx_q.delete();
    set_prof(0, 3'd1); set_prof(1, 3'd0); set_prof(2, 3'd2); set_prof(3, 3'd1);
    bus.rq_valid = 4'b1111;
    for (int i = 0; i < 200 && grant_q.size() < 6; i++) tick();
    @(posedge clk); #1 bus.rq_valid = '0;
    wait_idle("t2_idle");
    tick();
    exp2 = '{0, 1, 2, 3, 0, 1};
    check("t2_ngrant", grant_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      got = (k < grant_q.size()) ? grant_q[k] : -1;
      check($sformatf("t2_grant%0d", k), got, exp2[k]);
    end
    check("t2_ndone", done_idx_q.size(), 6);

    // Requester 2 locked while 1 and 3 compete
    grant_q.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_prof(i, 3'd2);
    bus.rq_lock  = 4'b0100;
    bus.rq_valid = 4'b1110;
    for (int i = 0; i < 200 && grant_q.size() < 3; i++) tick();
    @(posedge clk); #1;
    bus.rq_lock  = '0;
    bus.rq_valid = 4'b1010;
    for (int i = 0; i < 200 && grant_q.size() < 4; i++) tick();
    @(posedge clk); #1 bus.rq_valid = '0;
    wait_idle("t3_idle");
    tick();
    exp3 = '{2, 2, 2, 3};
    for (int k = 0; k < 4; k++) begin
      got = (k < grant_q.size()) ? grant_q[k] : -1;
      check($sformatf("t3_grant%0d", k), got, exp3[k]);
    end

    // Zero-wait profile back-to-back from requester 1
    grant_q.delete();
    done_idx_q.delete();
    done_cyc_q.delete();
    @(posedge clk); #1;
    set_prof(1, 3'd0);
    bus.rq_valid = 4'b0010;
    for (int i = 0; i < 100 && done_cyc_q.size() < 5; i++) tick();
    @(posedge clk); #1 bus.rq_valid = '0;
    wait_idle("t4_idle");
    tick();
    for (int k = 0; k < 4; k++) begin
      got = (k + 1 < done_cyc_q.size()) ? done_cyc_q[k+1] - done_cyc_q[k] : -1;
      check($sformatf("t4_gap%0d", k), got, 3);
    end
    check("t4_count", done_idx_q.size(), grant_q.size());
    got = 0;
    foreach (done_idx_q[k]) if (done_idx_q[k] != 1) got++;
    check("t4_all_req1", got, 0);

    // Lock, stale done at accept, timeout clears lock, late done ignored
    @(posedge clk); #1;
    set_prof(2, 3'd0);
    set_prof(0, 3'd1);
    bus.rq_lock  = 4'b0100;
    bus.rq_valid = 4'b0101;
    for (int i = 0; i < 30 && bus.rq_done == '0; i++) tick();
    check("t5_done1", bus.rq_done, 4'b0100);
    check("t5_regrant", bus.rq_ready, 4'b0100);
    @(posedge clk); #1;
    mute   = 1'b1;
    inject = 1'b1;
    tick();
    check("t5_issue", bus.wg_req_valid, 1);
    @(posedge clk); #1 inject = 1'b0;
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rq_err != '0) break;
      if (busy && !bus.wg_req_valid) waits++;
    end
    check("t5_wait_cycles", waits, 15);
    check("t5_err", bus.rq_err, 4'b0100);
    check("t5_no_done", bus.rq_done, 0);
    check("t5_idle_after_err", busy, 0);
    check("t5_lock_cleared", bus.rq_ready, 4'b0001);
    @(posedge clk); #1;
    bus.rq_valid = '0;
    bus.rq_lock  = '0;
    mute         = 1'b0;
    wait_idle("t5_idle");
    tick();
    @(posedge clk); #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    tick();
    check("t5_late_done", bus.rq_done, 0);
    check("t5_late_busy", busy, 0);

    // Asynchronous reset while requester 3 sits in WAIT
    @(posedge clk); #1;
    set_prof(3, 3'd2);
    mute         = 1'b1;
    bus.rq_valid = 4'b1000;
    for (int i = 0; i < 20 && !(busy && !bus.wg_req_valid); i++) tick();
    check("t6_owner3", owner, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_owner", owner, 0);
    check("t6_ready", bus.rq_ready, 0);
    check("t6_wgv", bus.wg_req_valid, 0);
    check("t6_wgprof", bus.wg_req_profile, 0);
    check("t6_done", bus.rq_done, 0);
    check("t6_err", bus.rq_err, 0);
    bus.rq_valid = 4'b1001;
    mute         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("t6_first_grant", bus.rq_ready, 4'b0001);
    @(posedge clk); #1 bus.rq_valid = '0;
    wait_idle("t6_idle");
    tick();

    check("mon_multihot", multihot, 0);
    check("mon_overlap", overlap, 0);
    check("mon_dup", dup, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
